// File: rtl/deser16_receiver.sv
// deser16_receiver: 16-bit serial-to-parallel receiver with a valid/ready hold register.
// Optional even-parity trailer bit and parity_err output when DESER16_PARITY_EN is defined.
module deser16_receiver #(
   parameter int MSB_FIRST = 0,
   parameter int CNT_W     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin_data,
   input  logic        sin_valid,
   input  logic        sin_first,
   output logic [15:0] pout,
   output logic        pout_valid,
   input  logic        pout_ready,
   input  logic        clr_ovr,
   output logic        overrun,
   output logic        frame_err,
`ifdef DESER16_PARITY_EN
   output logic        parity_err,
`endif
   output logic        busy
);

`ifdef DESER16_PARITY_EN
   typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   wr_idx;
   logic [CNT_W-1:0]   pos;
   logic [15:0]        asm_q;
   logic [15:0]        merged;
   logic [15:0]        dword;
   logic               take;
   logic               resync;
   logic               complete;
   logic               deliver;
   logic               load;
   logic               drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (sin_valid && sin_first) state_d = RECV;
         RECV: if (sin_valid && !sin_first && cnt_q == '1)
`ifdef DESER16_PARITY_EN
                  state_d = PAR;
`else
                  state_d = IDLE;
`endif
`ifdef DESER16_PARITY_EN
         PAR:  if (sin_valid) state_d = sin_first ? RECV : IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Any strobe carrying sin_first restarts the word at index 0 on a cleared assembly register.
   always_comb begin
      take     = 1'b0;
      resync   = 1'b0;
      complete = 1'b0;
      deliver  = 1'b0;
      busy     = (state_q != IDLE);
      case (state_q)
         IDLE: take = sin_valid && sin_first;
         RECV: begin
            take     = sin_valid;
            resync   = sin_valid && sin_first;
            complete = sin_valid && !sin_first && cnt_q == '1;
         end
`ifdef DESER16_PARITY_EN
         PAR: begin
            resync  = sin_valid && sin_first;
            take    = resync;
            deliver = sin_valid && !sin_first;
         end
`endif
         default: ;
      endcase
`ifndef DESER16_PARITY_EN
      deliver = complete;
`endif
   end

   always_comb begin
      wr_idx = (state_q == RECV && !sin_first) ? cnt_q : '0;
      pos    = (MSB_FIRST != 0) ? CNT_W'(15) - wr_idx : wr_idx;
      merged = sin_first ? '0 : asm_q;
      merged[pos] = sin_data;
`ifdef DESER16_PARITY_EN
      dword = asm_q;
`else
      dword = merged;
`endif
      load = deliver && (!pout_valid || pout_ready);
      drop = deliver && !load;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         asm_q <= '0;
      end else begin
         if (take) begin
            cnt_q <= wr_idx + CNT_W'(1);
            asm_q <= merged;
         end
`ifdef DESER16_PARITY_EN
         if (complete) cnt_q <= '0;
         if (deliver)  asm_q <= '0;
`else
         if (complete) begin
            cnt_q <= '0;
            asm_q <= '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pout       <= '0;
         pout_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (load) begin
            pout       <= dword;
            pout_valid <= 1'b1;
         end else if (pout_ready) begin
            pout_valid <= 1'b0;
         end
         overrun   <= drop | (overrun & ~clr_ovr);
         frame_err <= resync;
      end
   end

`ifdef DESER16_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      parity_err <= 1'b0;
      else if (load) parity_err <= (^asm_q) ^ sin_data;
   end
`endif

endmodule
